// File: rtl/npu_pkg.sv
// Shared types and widths for the NPU softmax command path.
package npu_pkg;

    localparam int SMX_ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } softmax_sched_state_t;

endpackage

// File: rtl/softmax_row_scheduler.sv
// Walks a softmax engine over every row of a score matrix, issuing one
// stride-advanced row command at a time and pulsing done at the end.
module softmax_row_scheduler
    import npu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SMX_ADDR_W-1:0] num_rows,
    input  logic [SMX_ADDR_W-1:0] row_len,
    input  logic [SMX_ADDR_W-1:0] src_base,
    input  logic [SMX_ADDR_W-1:0] dst_base,
    input  logic [SMX_ADDR_W-1:0] src_stride,
    input  logic [SMX_ADDR_W-1:0] dst_stride,
    input  logic [SMX_ADDR_W-1:0] scale_factor,
    input  logic                  causal_en,
    input  logic [SMX_ADDR_W-1:0] causal_offset,
    output logic                  eng_cmd_valid,
    input  logic                  eng_cmd_ready,
    output logic [SMX_ADDR_W-1:0] eng_length,
    output logic [SMX_ADDR_W-1:0] eng_src_base,
    output logic [SMX_ADDR_W-1:0] eng_dst_base,
    output logic [SMX_ADDR_W-1:0] eng_scale_factor,
    output logic [SMX_ADDR_W-1:0] eng_causal_limit,
    output logic                  eng_causal_mask_en,
    input  logic                  eng_done,
    output logic [SMX_ADDR_W-1:0] row_idx,
    output logic                  busy,
    output logic                  done
);

    softmax_sched_state_t state_q, state_d;

    logic [SMX_ADDR_W-1:0] num_rows_q, num_rows_d;
    logic [SMX_ADDR_W-1:0] row_len_q, row_len_d;
    logic [SMX_ADDR_W-1:0] src_stride_q, src_stride_d;
    logic [SMX_ADDR_W-1:0] dst_stride_q, dst_stride_d;
    logic [SMX_ADDR_W-1:0] scale_q, scale_d;
    logic [SMX_ADDR_W-1:0] causal_offset_q, causal_offset_d;
    logic                  causal_en_q, causal_en_d;
    logic [SMX_ADDR_W-1:0] row_idx_q, row_idx_d;
    logic [SMX_ADDR_W-1:0] cur_src_q, cur_src_d;
    logic [SMX_ADDR_W-1:0] cur_dst_q, cur_dst_d;
    logic [SMX_ADDR_W-1:0] limit_q, limit_d;
    logic [SMX_ADDR_W:0]   limit_sum_s;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  eng_cmd_valid_q, eng_cmd_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Sequencing: command capture, handshake tracking and row advance
    always_comb begin
        state_d         = state_q;
        num_rows_d      = num_rows_q;
        row_len_d       = row_len_q;
        src_stride_d    = src_stride_q;
        dst_stride_d    = dst_stride_q;
        scale_d         = scale_q;
        causal_offset_d = causal_offset_q;
        causal_en_d     = causal_en_q;
        row_idx_d       = row_idx_q;
        cur_src_d       = cur_src_q;
        cur_dst_d       = cur_dst_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    num_rows_d      = num_rows;
                    row_len_d       = row_len;
                    src_stride_d    = src_stride;
                    dst_stride_d    = dst_stride;
                    scale_d         = scale_factor;
                    causal_offset_d = causal_offset;
                    causal_en_d     = causal_en;
                    row_idx_d       = 16'd0;
                    cur_src_d       = src_base;
                    cur_dst_d       = dst_base;
                    if ((num_rows == 16'd0) || (row_len == 16'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (eng_cmd_valid_q && eng_cmd_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                if (row_idx_q == (num_rows_q - 16'd1)) begin
                    state_d = S_DONE;
                end else begin
                    row_idx_d = row_idx_q + 16'd1;
                    cur_src_d = cur_src_q + src_stride_q;
                    cur_dst_d = cur_dst_q + dst_stride_q;
                    state_d   = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Causal limit for the row being presented, clamped to 16 bits
    always_comb begin
        limit_sum_s = {1'b0, row_idx_d} + {1'b0, causal_offset_d};
        if (limit_sum_s[SMX_ADDR_W]) begin
            limit_d = 16'hFFFF;
        end else begin
            limit_d = limit_sum_s[SMX_ADDR_W-1:0];
        end
    end

    // Status outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        cmd_ready_d     = (state_d == S_IDLE);
        eng_cmd_valid_d = (state_d == S_ISSUE);
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            num_rows_q      <= 16'd0;
            row_len_q       <= 16'd0;
            src_stride_q    <= 16'd0;
            dst_stride_q    <= 16'd0;
            scale_q         <= 16'd0;
            causal_offset_q <= 16'd0;
            causal_en_q     <= 1'b0;
            row_idx_q       <= 16'd0;
            cur_src_q       <= 16'd0;
            cur_dst_q       <= 16'd0;
            limit_q         <= 16'd0;
            cmd_ready_q     <= 1'b1;
            eng_cmd_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_rows_q      <= num_rows_d;
            row_len_q       <= row_len_d;
            src_stride_q    <= src_stride_d;
            dst_stride_q    <= dst_stride_d;
            scale_q         <= scale_d;
            causal_offset_q <= causal_offset_d;
            causal_en_q     <= causal_en_d;
            row_idx_q       <= row_idx_d;
            cur_src_q       <= cur_src_d;
            cur_dst_q       <= cur_dst_d;
            limit_q         <= limit_d;
            cmd_ready_q     <= cmd_ready_d;
            eng_cmd_valid_q <= eng_cmd_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign eng_cmd_valid      = eng_cmd_valid_q;
    assign eng_length         = row_len_q;
    assign eng_src_base       = cur_src_q;
    assign eng_dst_base       = cur_dst_q;
    assign eng_scale_factor   = scale_q;
    assign eng_causal_limit   = limit_q;
    assign eng_causal_mask_en = causal_en_q;
    assign row_idx            = row_idx_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: doc/softmax_row_scheduler.md
# softmax_row_scheduler

Sequences the softmax engine over a full attention score matrix, one row per engine command. Accepts a single matrix-level command from the NPU controller and issues one row command per row. Each row command carries a stride-advanced source/destination base and a per-row causal limit. Sits between the top-level command decoder and the softmax engine's command/done interface; it does not touch SRAM itself.

## Interface
Parameters:
- none (all widths fixed at 16 bits, matching the engine command fields)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  matrix command request
- cmd_ready  out  1  high in IDLE only
- num_rows  in  16  rows to process
- row_len  in  16  elements per row
- src_base  in  16  SRAM address of row 0 scores
- dst_base  in  16  SRAM address of row 0 probabilities
- src_stride  in  16  address step between input rows
- dst_stride  in  16  address step between output rows
- scale_factor  in  16  Q8.8 attention scale, forwarded unchanged
- causal_en  in  1  enable causal masking
- causal_offset  in  16  limit for row r = r + causal_offset
- eng_cmd_valid  out  1  row command to engine
- eng_cmd_ready  in  1  engine idle
- eng_length, eng_src_base, eng_dst_base, eng_scale_factor, eng_causal_limit  out  16 each  row command fields
- eng_causal_mask_en  out  1  row mask enable
- eng_done  in  1  engine one-cycle completion pulse
- row_idx  out  16  current row
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when matrix completes

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE.
- S_IDLE:
  - cmd_ready=1.
  - On cmd_valid, register all command fields and set row_idx=0, cur_src=src_base, cur_dst=dst_base.
  - If num_rows==0 or row_len==0, go to S_DONE with no engine command.
  - Otherwise go to S_ISSUE.
- S_ISSUE:
  - eng_cmd_valid=1.
  - Stay until eng_cmd_valid&&eng_cmd_ready, then go to S_WAIT.
- S_WAIT: on eng_done, go to S_NEXT.
- S_NEXT:
  - If row_idx==num_rows-1, go to S_DONE.
  - Otherwise row_idx+=1, cur_src+=src_stride, cur_dst+=dst_stride, go to S_ISSUE.
- S_DONE: done=1 for one cycle, then go to S_IDLE.
- Engine fields are driven from registers, not combinationally from the inputs:
  - eng_length=row_len
  - eng_src_base=cur_src
  - eng_dst_base=cur_dst
  - eng_scale_factor=scale_factor
  - eng_causal_mask_en=causal_en
  - eng_causal_limit=sat16(row_idx+causal_offset)
- Arithmetic and width rules:
  - Address adds are 16-bit and wrap modulo 2^16.
  - The causal limit is computed in 17 bits and saturates to 0xFFFF.
- eng_done received in any state other than S_WAIT is ignored.
- cmd_valid outside S_IDLE is ignored; parameters of a running matrix never change.

## Timing
- Reset values:
  - state=S_IDLE, cmd_ready=1, eng_cmd_valid=0, busy=0, done=0.
  - row_idx=0 and all eng_* fields = 0.
- Cycle sequence:
  - Command accepted at edge T; eng_cmd_valid is high from cycle T+1.
  - Engine handshake at edge H; S_WAIT from H+1.
  - eng_done at edge D; S_NEXT in D+1; next S_ISSUE (row advanced) in D+2.
- Scheduler overhead per row: 2 cycles plus handshake wait.
- Last row: done asserted in cycle D+2; cmd_ready high in D+3.
- Empty command: done asserted in T+1, IDLE in T+2.
- eng_* fields are stable for the whole time eng_cmd_valid is high.
- Reset mid-operation:
  - Immediate return to IDLE; no done pulse.
  - The engine shares rst and is reset with the scheduler.

## Structure
- npu_pkg gets the softmax_sched_state_t enum and a SMX_ADDR_W=16 constant.
- Single flat module. The softmax engine is instantiated by the parent, not inside this block.
- No sub-module is needed; the causal-limit saturating adder is an inline always_comb.

## Test plan
- 3 rows (row_len=8, src=0x100, dst=0x200, strides=8/16, causal_offset=0, causal_en=1), bench engine model done 10 cycles after each accept:
  - exactly 3 engine commands with src 0x100/0x108/0x110, dst 0x200/0x210/0x220, limits 0/1/2;
  - one done pulse.
- Engine holds eng_cmd_ready=0 for 5 cycles on row 1 -> eng_cmd_valid stays high with constant fields; no duplicate accept.
- num_rows=0 -> no eng_cmd_valid; done at T+1; cmd_ready back at T+2.
- src_base=0xFFF8, stride=8, 2 rows -> row 1 src=0x0000; causal_offset=0xFFFF, row 1 -> limit 0xFFFF (saturated).
- Spurious eng_done in S_ISSUE, and cmd_valid held while busy -> ignored; row count and addresses unchanged.
- rst asserted during S_WAIT of row 1 -> next cycle IDLE, cmd_ready=1, row_idx=0, no done; a new command afterwards starts at row 0.
